// File: rtl/instr_encoder_if.sv
// Loader-facing field handshake plus the instruction-memory write port of instr_encoder.
// The loader holds the master modport and the encoder holds the slave modport.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [63:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32 fields into instruction words and writes them to consecutive
// instruction-memory addresses, rejecting out-of-range or misaligned immediates.
module instr_encoder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    instr_encoder_if.slave  bus,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            err,
    output logic [1:0]      err_code
);

    localparam logic [2:0] FmtR = 3'd0;
    localparam logic [2:0] FmtI = 3'd1;
    localparam logic [2:0] FmtS = 3'd2;
    localparam logic [2:0] FmtB = 3'd3;
    localparam logic [2:0] FmtU = 3'd4;
    localparam logic [2:0] FmtJ = 3'd5;

    typedef enum logic [1:0] {
        ErrNone  = 2'b00,
        ErrRange = 2'b01,
        ErrAlign = 2'b10,
        ErrFmt   = 2'b11
    } err_e;

    localparam logic signed [63:0] ImmIMin = -64'sd2048;
    localparam logic signed [63:0] ImmIMax = 64'sd2047;
    localparam logic signed [63:0] ImmBMin = -64'sd4096;
    localparam logic signed [63:0] ImmBMax = 64'sd4094;
    localparam logic signed [63:0] ImmJMin = -64'sd1048576;
    localparam logic signed [63:0] ImmJMax = 64'sd1048574;
    localparam logic signed [63:0] ImmUMin = -64'sd2147483648;
    localparam logic signed [63:0] ImmUMax = 64'sd2147479552;

    localparam logic [ADDR_W-1:0] BaseW  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W+1:0] DepthW = (ADDR_W + 2)'(DEPTH);

    // Stage-1 holding register; only the low 32 immediate bits are ever packed.
    logic        s1_valid_q, s1_valid_d;
    err_e        s1_code_q;
    logic [2:0]  s1_fmt_q;
    logic [6:0]  s1_opcode_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [2:0]  s1_funct3_q;
    logic [6:0]  s1_funct7_q;
    logic [31:0] s1_imm_q;

    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    err_e              code_q, code_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              accept;
    logic [ADDR_W+1:0] occupancy;
    err_e              chk_code;
    logic signed [63:0] imm_s;
    logic [31:0]       pack_word;

    // Occupancy counts the tuple still sitting in stage 1 so full asserts one cycle early.
    assign occupancy    = {1'b0, count_q} + (ADDR_W + 2)'(s1_valid_q);
    assign full         = (occupancy >= DepthW);
    assign bus.in_ready = !full && !start && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    assign count         = count_q;
    assign err           = err_q;
    assign err_code      = code_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Legality of the incoming tuple; alignment is judged before range.
    always_comb begin
        chk_code = ErrNone;
        imm_s    = $signed(bus.in_imm);
        case (bus.in_fmt)
            FmtR: chk_code = ErrNone;
            FmtI, FmtS: begin
                if (imm_s < ImmIMin || imm_s > ImmIMax) chk_code = ErrRange;
            end
            FmtB: begin
                if (bus.in_imm[0]) chk_code = ErrAlign;
                else if (imm_s < ImmBMin || imm_s > ImmBMax) chk_code = ErrRange;
            end
            FmtJ: begin
                if (bus.in_imm[0]) chk_code = ErrAlign;
                else if (imm_s < ImmJMin || imm_s > ImmJMax) chk_code = ErrRange;
            end
            FmtU: begin
                if (|bus.in_imm[11:0]) chk_code = ErrAlign;
                else if (imm_s < ImmUMin || imm_s > ImmUMax) chk_code = ErrRange;
            end
            default: chk_code = ErrFmt;
        endcase
    end

    always_comb begin
        pack_word = 32'h0;
        case (s1_fmt_q)
            FmtR: pack_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q,
                               s1_opcode_q};
            FmtI: pack_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            FmtS: pack_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                               s1_opcode_q};
            FmtB: pack_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                               s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
            FmtU: pack_word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
            FmtJ: pack_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                               s1_rd_q, s1_opcode_q};
            default: pack_word = 32'h0;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        count_d     = count_q;
        err_d       = err_q;
        code_d      = code_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (start) begin
            s1_valid_d = 1'b0;
            count_d    = '0;
            err_d      = 1'b0;
            code_d     = ErrNone;
        end else begin
            s1_valid_d = accept;
            if (s1_valid_q) begin
                if (s1_code_q == ErrNone) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BaseW + count_q[ADDR_W-1:0];
                    mem_wdata_d = pack_word;
                    count_d     = count_q + (ADDR_W + 1)'(1);
                end else begin
                    err_d = 1'b1;
                    // Only the first error since reset/start is reported.
                    if (!err_q) code_d = s1_code_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            code_q      <= ErrNone;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            count_q     <= count_d;
            err_q       <= err_d;
            code_q      <= code_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Field payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_code_q   <= chk_code;
            s1_fmt_q    <= bus.in_fmt;
            s1_opcode_q <= bus.in_opcode;
            s1_rd_q     <= bus.in_rd;
            s1_rs1_q    <= bus.in_rs1;
            s1_rs2_q    <= bus.in_rs2;
            s1_funct3_q <= bus.in_funct3;
            s1_funct7_q <= bus.in_funct7;
            s1_imm_q    <= bus.in_imm[31:0];
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized tuples scored
// against a field-level encoding model.
module tb_instr_encoder;

    localparam int unsigned ADDR_W = 10;
    localparam longint Bounds [19] = '{
        -2048, -2049, 2047, 2048, -4096, -4098, 4094, 4096, -1048576, -1048578,
        1048574, 1048576, 64'sh7FFFF000, 64'sh80000000, -64'sh80000000, -64'sh80001000,
        64'sh12345000, 64'sh12345001, 3
    };

    logic clk = 1'b0;
    logic rst, start, start4;
    logic [ADDR_W:0] count, count4;
    logic full, full4, err, err4;
    logic [1:0] err_code, err_code4;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();
    instr_encoder_if #(.ADDR_W(ADDR_W)) bus4 ();

    instr_encoder #(.DEPTH(1024), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .count(count), .full(full), .err(err), .err_code(err_code)
    );

    instr_encoder #(.DEPTH(4), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bus(bus4),
        .count(count4), .full(full4), .err(err4), .err_code(err_code4)
    );

    // Returns {err_code, word}; word is meaningful only when err_code is 0.
    function automatic logic [33:0] ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [2:0] f3,
                                               input logic [6:0] f7, input longint imm);
        logic [31:0] w;
        logic [1:0] code;
        logic [31:0] base_rs;
        w = 32'h0;
        code = 2'b00;
        base_rs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (fmt)
            3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | base_rs | (32'(rd) << 7);
            3'd1: begin
                if (imm < -2048 || imm > 2047) code = 2'b01;
                w = (32'(imm & 64'hFFF) << 20) | base_rs | (32'(rd) << 7);
            end
            3'd2: begin
                if (imm < -2048 || imm > 2047) code = 2'b01;
                w = (32'((imm >> 5) & 64'h7F) << 25) | (32'(rs2) << 20) | base_rs
                    | (32'(imm & 64'h1F) << 7);
            end
            3'd3: begin
                if ((imm & 1) != 0) code = 2'b10;
                else if (imm < -4096 || imm > 4094) code = 2'b01;
                w = (32'((imm >> 12) & 1) << 31) | (32'((imm >> 5) & 64'h3F) << 25)
                    | (32'(rs2) << 20) | base_rs | (32'((imm >> 1) & 64'hF) << 8)
                    | (32'((imm >> 11) & 1) << 7);
            end
            3'd4: begin
                if ((imm & 4095) != 0) code = 2'b10;
                else if (imm < -64'sd2147483648 || imm > 64'sd2147479552) code = 2'b01;
                w = 32'(imm & 64'hFFFFF000) | (32'(rd) << 7) | 32'(op);
            end
            3'd5: begin
                if ((imm & 1) != 0) code = 2'b10;
                else if (imm < -1048576 || imm > 1048574) code = 2'b01;
                w = (32'((imm >> 20) & 1) << 31) | (32'((imm >> 1) & 64'h3FF) << 21)
                    | (32'((imm >> 11) & 1) << 20) | (32'((imm >> 12) & 64'hFF) << 12)
                    | (32'(rd) << 7) | 32'(op);
            end
            default: code = 2'b11;
        endcase
        return {code, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tuple(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [63:0] imm);
        bus.in_valid = 1'b1;
        bus.in_fmt = fmt;
        bus.in_opcode = op;
        bus.in_rd = rd;
        bus.in_rs1 = rs1;
        bus.in_rs2 = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm = imm;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin failures++;
            $display("FAIL reset_ready: got %0b expected 0", bus.in_ready); end
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin
            failures++; $display("FAIL reset_mem: we=%0b addr=%0h wdata=%08h expected 0/0/0",
                                 bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        checks++; if (count !== '0 || full !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
            failures++; $display("FAIL reset_status: count=%0d full=%0b err=%0b code=%0b expected 0",
                                 count, full, err, err_code); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++;
            $display("FAIL reset_release_ready: got %0b expected 1", bus.in_ready); end
    endtask

    task automatic test_itype();
        set_tuple(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd3);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.mem_we !== 1'b0) begin failures++;
            $display("FAIL itype_early_we: got %0b expected 0", bus.mem_we); end
        tick();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd0 || bus.mem_wdata !== 32'hFFD00093)
        begin failures++; $display("FAIL itype_write: we=%0b addr=%0d wdata=%08h expected 1/0/ffd00093",
                                   bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        checks++; if (count !== 11'd1) begin failures++;
            $display("FAIL itype_count: got %0d expected 1", count); end
        tick();
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'hFFD00093) begin failures++;
            $display("FAIL itype_single_strobe: we=%0b wdata=%08h expected 0/ffd00093",
                     bus.mem_we, bus.mem_wdata); end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        checks++; if (count !== '0) begin failures++;
            $display("FAIL b2b_start_count: got %0d expected 0", count); end
        set_tuple(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd3, 7'd0, -64'sd32);
        tick();
        set_tuple(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd8);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd0 || bus.mem_wdata !== 32'hFE21B023)
        begin failures++; $display("FAIL b2b_store: we=%0b addr=%0d wdata=%08h expected 1/0/fe21b023",
                                   bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        tick();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd1 || bus.mem_wdata !== 32'h00208463)
        begin failures++; $display("FAIL b2b_branch: we=%0b addr=%0d wdata=%08h expected 1/1/00208463",
                                   bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    endtask

    task automatic test_errors();
        pulse_start();
        set_tuple(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.mem_we !== 1'b0 || err !== 1'b1 || err_code !== 2'b01 || count !== '0) begin
            failures++; $display("FAIL err_range: we=%0b err=%0b code=%0b count=%0d expected 0/1/01/0",
                                 bus.mem_we, err, err_code, count); end
        set_tuple(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd5);
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.mem_we !== 1'b0 || err_code !== 2'b01) begin failures++;
            $display("FAIL err_first_held: we=%0b code=%0b expected 0/01", bus.mem_we, err_code); end
        set_tuple(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd3);
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd0 || count !== 11'd1 || err !== 1'b1)
        begin failures++; $display("FAIL err_then_legal: we=%0b addr=%0d count=%0d err=%0b expected 1/0/1/1",
                                   bus.mem_we, bus.mem_addr, count, err); end
        pulse_start();
        set_tuple(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.mem_we !== 1'b0 || err_code !== 2'b11) begin failures++;
            $display("FAIL err_fmt: we=%0b code=%0b expected 0/11", bus.mem_we, err_code); end
        pulse_start();
        checks++; if (err !== 1'b0 || err_code !== 2'b00) begin failures++;
            $display("FAIL start_clears_err: err=%0b code=%0b expected 0/00", err, err_code); end
        set_tuple(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000);
        tick();
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd0 || bus.mem_wdata !== 32'h123452B7)
        begin failures++; $display("FAIL utype: we=%0b addr=%0d wdata=%08h expected 1/0/123452b7",
                                   bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    endtask

    task automatic test_rst_flush();
        set_tuple(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 64'd7);
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0
                      || count !== '0 || err !== 1'b0 || bus.in_ready !== 1'b0) begin failures++;
            $display("FAIL rst_flush: we=%0b addr=%0d wdata=%08h count=%0d err=%0b ready=%0b expected 0/0/0/0/0/0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, count, err, bus.in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++;
            $display("FAIL rst_flush_ready: got %0b expected 1", bus.in_ready); end
        tick();
        checks++; if (bus.mem_we !== 1'b0 || count !== '0) begin failures++;
            $display("FAIL rst_flush_no_write: we=%0b count=%0d expected 0/0", bus.mem_we, count); end
    endtask

    task automatic test_full();
        int nwr;
        logic [33:0] r;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        nwr = 0;
        for (int i = 0; i < 10; i++) begin
            bus4.in_valid = (i < 6);
            bus4.in_fmt = 3'd1;
            bus4.in_opcode = 7'h13;
            bus4.in_rd = 5'(i + 1);
            bus4.in_rs1 = 5'd0;
            bus4.in_rs2 = 5'd0;
            bus4.in_funct3 = 3'd0;
            bus4.in_funct7 = 7'd0;
            bus4.in_imm = 64'(i);
            tick();
            if (bus4.mem_we === 1'b1) begin
                r = ref_encode(3'd1, 7'h13, 5'(nwr + 1), 5'd0, 5'd0, 3'd0, 7'd0, longint'(nwr));
                checks++; if (bus4.mem_addr !== 10'(nwr) || bus4.mem_wdata !== r[31:0]) begin
                    failures++; $display("FAIL full_write%0d: addr=%0d wdata=%08h expected %0d/%08h",
                                         nwr, bus4.mem_addr, bus4.mem_wdata, nwr, r[31:0]); end
                nwr++;
            end
        end
        checks++; if (nwr != 4) begin failures++;
            $display("FAIL full_write_count: got %0d expected 4", nwr); end
        checks++; if (count4 !== 11'd4 || full4 !== 1'b1 || bus4.in_ready !== 1'b0) begin failures++;
            $display("FAIL full_state: count=%0d full=%0b ready=%0b expected 4/1/0",
                     count4, full4, bus4.in_ready); end
        start4 = 1'b1;
        #1;
        checks++; if (bus4.in_ready !== 1'b0) begin failures++;
            $display("FAIL full_start_ready: got %0b expected 0", bus4.in_ready); end
        tick();
        start4 = 1'b0;
        #1;
        checks++; if (count4 !== '0 || err4 !== 1'b0 || full4 !== 1'b0 || bus4.in_ready !== 1'b1) begin
            failures++; $display("FAIL full_restart: count=%0d err=%0b full=%0b ready=%0b expected 0/0/0/1",
                                 count4, err4, full4, bus4.in_ready); end
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        tick();
        checks++; if (bus4.mem_we !== 1'b1 || bus4.mem_addr !== 10'd0) begin failures++;
            $display("FAIL full_after_start: we=%0b addr=%0d expected 1/0", bus4.mem_we, bus4.mem_addr); end
    endtask

    task automatic test_random();
        int m_count;
        bit m_err, pend, acc, exp_ready, exp_we;
        logic [1:0] m_code;
        logic [33:0] cur_ref, pend_ref;
        logic [31:0] exp_wdata;
        logic [2:0] f;
        longint imm;
        pulse_start();
        m_count = 0;
        m_err = 1'b0;
        m_code = 2'b00;
        pend = 1'b0;
        pend_ref = '0;
        cur_ref = '0;
        exp_wdata = '0;
        for (int i = 0; i < 400; i++) begin
            if (i < 399 && $urandom_range(0, 3) != 0) begin
                f = ($urandom_range(0, 9) != 0) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
                case ($urandom_range(0, 3))
                    0: imm = Bounds[$urandom_range(0, 18)];
                    1: imm = longint'($urandom_range(0, 10000)) - 5000;
                    2: imm = (longint'($urandom_range(0, 32'hFFFFF)) << 12) - 64'sd2147483648;
                    default: imm = longint'({$urandom, $urandom});
                endcase
                set_tuple(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                          7'($urandom), 64'(imm));
                cur_ref = ref_encode(f, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                                     bus.in_funct3, bus.in_funct7, imm);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            exp_ready = (m_count + int'(pend)) < 1024;
            checks++; if (bus.in_ready !== exp_ready) begin failures++;
                $display("FAIL rand_ready[%0d]: got %0b expected %0b", i, bus.in_ready, exp_ready); end
            acc = bus.in_valid && exp_ready;
            @(posedge clk);
            #1;
            exp_we = 1'b0;
            if (pend) begin
                if (pend_ref[33:32] == 2'b00) begin
                    exp_we = 1'b1;
                    exp_wdata = pend_ref[31:0];
                    m_count++;
                end else begin
                    if (!m_err) m_code = pend_ref[33:32];
                    m_err = 1'b1;
                end
            end
            pend = acc;
            pend_ref = cur_ref;
            checks++; if (bus.mem_we !== exp_we) begin failures++;
                $display("FAIL rand_we[%0d]: got %0b expected %0b", i, bus.mem_we, exp_we); end
            if (exp_we) begin
                checks++; if (bus.mem_addr !== 10'(m_count - 1) || bus.mem_wdata !== exp_wdata) begin
                    failures++; $display("FAIL rand_write[%0d]: addr=%0d wdata=%08h expected %0d/%08h",
                                         i, bus.mem_addr, bus.mem_wdata, m_count - 1, exp_wdata); end
            end
            checks++; if (count !== 11'(m_count) || err !== m_err || err_code !== m_code) begin
                failures++; $display("FAIL rand_status[%0d]: count=%0d err=%0b code=%0b expected %0d/%0b/%0b",
                                     i, count, err, err_code, m_count, m_err, m_code); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_itype();
        test_back_to_back();
        test_errors();
        test_rst_flush();
        test_full();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Encodes decoded RISC-V instruction fields back into 32-bit instruction words and writes them into instruction memory at consecutive addresses. It is the inverse of the immediate generator: it takes a sign-extended 64-bit immediate plus register and funct fields, range-checks the immediate for the selected format, and packs the bits. It sits between the test/boot loader and the instruction memory write port of the single-cycle core.

## Interface
- DEPTH, 1024: number of instruction words the block may write.
- ADDR_W, 10: word-address width of the instruction memory.
- BASE_ADDR, 0: first word address written after reset or `start`.

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  synchronous restart: flush, pointer to BASE_ADDR, clear count and error
- in_valid  in  1  field tuple valid
- in_ready  out  1  block accepts the tuple this cycle
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 illegal
- in_opcode  in  7  opcode[6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_imm  in  64  signed immediate, byte offset for B/J, full value for U
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset/start
- full  out  1  no further tuple accepted
- err  out  1  sticky error flag
- err_code  out  2  first error: 01 range, 10 misaligned, 11 illegal format

## Operation
- Handshake: transfer when `in_valid && in_ready` at a rising edge; fields need only be stable that cycle.
- Stage 1 (capture): register fields; compute legality.
  - I, S: imm in [-2048, 2047].
  - B: imm[0]=0 (else misaligned); imm in [-4096, 4094].
  - J: imm[0]=0; imm in [-1048576, 1048574].
  - U: imm[11:0]=0 (else misaligned); imm in [-2^31, 2^31-4096].
  - R: imm ignored, always legal.
  - Misalignment is checked before range; illegal format overrides both.
- Stage 2 (write): legal tuples pack per standard RV32 layouts.
  - R: f7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - Unused fields for a format are ignored, never packed.
  - On the write: mem_we=1, mem_addr = (BASE_ADDR + count) mod 2^ADDR_W, count+1.
- Illegal tuples: no write, count unchanged, err←1; err_code loads only if err was 0 (first error held).
- full = (count + stage-1 pending) ≥ DEPTH; in_ready = !full && !start && !rst.
- start: stage 1 emptied (pending tuple dropped, no write), count←0, err←0, err_code←0; input not accepted that cycle.
- Reset values: in_ready 0 during rst, 1 the cycle after; mem_we 0, mem_addr 0, mem_wdata 0, count 0, full 0, err 0, err_code 00.

## Timing
- Latency: accept at edge E0 → mem_we/addr/wdata valid for exactly the cycle after edge E1; count and err update at E1.
- Throughput: one tuple per cycle, sustained until full.
- mem_we is never high two cycles for the same tuple; mem_addr/mem_wdata hold last value when mem_we=0.
- rst or start at E1 with a tuple in stage 1: no write occurs.
- full asserts combinationally in the cycle stage 1 holds the DEPTH-th tuple; an illegal tuple in that slot releases full one cycle later.

## Test plan
- I-type fmt=1, op=0010011, rd=1, rs1=0, f3=0, imm=-3 → after one cycle mem_we=1, mem_addr=0, mem_wdata=0xFFD00093, count=1.
- S-type fmt=2, op=0100011, rs1=3, rs2=2, f3=011, imm=-32, then B-type fmt=3, op=1100011, rs1=1, rs2=2, f3=0, imm=8, back-to-back → writes 0xFE21B023 @0 and 0x00208463 @1 on consecutive cycles.
- I-type imm=2048 → no mem_we, err=1, err_code=01; following B-type imm=5 keeps err_code=01; next legal tuple writes @ unchanged address.
- DEPTH=4, in_valid held high with 6 legal tuples → exactly 4 writes to addresses 0–3, full=1, in_ready=0; pulse start → count=0, err=0, in_ready=1, next write @0.
- Accept tuple, assert rst the next cycle → no mem_we; all outputs at reset values; in_ready=1 the cycle after rst drops.
- fmt=6 → err_code=11, no write; U-type imm=0x12345000, rd=5, op=0110111 after start → mem_wdata=0x123452B7.
